cost_port_arbiter: RTL and testbench

Round-robin, burst-locking arbiter that shares the single Cost lookup port (W/J out, Cost in) between up to NREQ assignment-search engines. Each engine issues worker/job address beats, one lookup per cycle. The arbiter grants one beat per cycle and holds the port for the owning engine until that engine's LAST beat, so a permutation's 8-term sum is never interleaved. Looked-up costs return to the owner as registered data one cycle after each grant.

---
 rtl/cost_port_arbiter_if.sv | 34 +++
 rtl/cost_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_cost_port_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cost_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cost_port_arbiter_if
// Description : Request/grant/return bundle between search engines and the
//               shared cost lookup port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cost_port_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   REQ;
  logic [3*NREQ-1:0] REQ_W;
  logic [3*NREQ-1:0] REQ_J;
  logic [NREQ-1:0]   REQ_LAST;
  logic [NREQ-1:0]   GNT;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [6:0]        Cost;
  logic [NREQ-1:0]   RVALID;
  logic [6:0]        RDATA;
  logic              BUSY;
  logic              ERR;

  modport master (
    output REQ, REQ_W, REQ_J, REQ_LAST, Cost,
    input  GNT, W, J, RVALID, RDATA, BUSY, ERR
  );

  modport slave (
    input  REQ, REQ_W, REQ_J, REQ_LAST, Cost,
    output GNT, W, J, RVALID, RDATA, BUSY, ERR
  );
endinterface
`default_nettype wire

// File: rtl/cost_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cost_port_arbiter
// Description : Round-robin, burst-locking arbiter for the shared cost port.
// Revision    : 1.0 - initial release
// ============================================================================
module cost_port_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 8
) (
  input  logic             CLK,
  input  logic             RST,
  cost_port_arbiter_if.slave bus
);

  localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_CW = $clog2(MAXBURST + 1);

  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_LOCKED = 1'b1;

  logic [0:0]      r_state,  w_state_nxt;
  logic [c_PW-1:0] r_owner,  w_owner_nxt;
  logic [c_PW-1:0] r_ptr,    w_ptr_nxt;
  logic [c_CW-1:0] r_cnt,    w_cnt_nxt;
  logic            r_err,    w_err_nxt;
  logic [NREQ-1:0] r_rvalid;
  logic [6:0]      r_rdata;

  logic            w_rr_hit;
  logic [c_PW-1:0] w_rr_idx;
  logic [c_PW-1:0] w_cand;
  logic            w_gnt_vld;
  logic [c_PW-1:0] w_gnt_idx;
  logic            w_last;
  logic [c_CW-1:0] w_cnt_inc;

  // Descending scan so the nearest requester after ptr is the one that sticks.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = c_PW'((int'(r_ptr) + k) % NREQ);
      if (bus.REQ[w_cand]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_cand;
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= c_IDLE;
      r_owner  <= '0;
      r_ptr    <= c_PW'(NREQ - 1);
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
      r_rvalid <= bus.GNT;
      if (w_gnt_vld) begin
        r_rdata <= bus.Cost;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_cnt_inc   = r_cnt + c_CW'(1);
    case (r_state)
      c_IDLE: begin
        if (w_gnt_vld) begin
          if (w_last) begin
            w_ptr_nxt = w_gnt_idx;
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = c_LOCKED;
            w_owner_nxt = w_gnt_idx;
            w_cnt_nxt   = c_CW'(1);
          end
        end
      end
      c_LOCKED: begin
        if (w_gnt_vld) begin
          // Hitting the beat limit without LAST releases the lock and flags it.
          if (w_last || (w_cnt_inc == c_CW'(MAXBURST))) begin
            w_state_nxt = c_IDLE;
            w_ptr_nxt   = r_owner;
            w_cnt_nxt   = '0;
            if (!w_last) begin
              w_err_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic: grant is suppressed while reset is held
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    bus.GNT   = '0;
    bus.W     = '0;
    bus.J     = '0;
    if (RST) begin
      if (r_state == c_IDLE) begin
        w_gnt_vld = w_rr_hit;
        w_gnt_idx = w_rr_idx;
      end else begin
        w_gnt_vld = bus.REQ[r_owner];
        w_gnt_idx = r_owner;
      end
    end
    w_last = w_gnt_vld & bus.REQ_LAST[w_gnt_idx];
    if (w_gnt_vld) begin
      bus.GNT[w_gnt_idx] = 1'b1;
      bus.W = bus.REQ_W[3*int'(w_gnt_idx) +: 3];
      bus.J = bus.REQ_J[3*int'(w_gnt_idx) +: 3];
    end
  end

  assign bus.RVALID = r_rvalid;
  assign bus.RDATA  = r_rdata;
  assign bus.BUSY   = (r_state == c_LOCKED);
  assign bus.ERR    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cost_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cost_port_arbiter
// Description : Randomized bench for cost_port_arbiter against a burst-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cost_port_arbiter;

  localparam int NREQ     = 4;
  localparam int MAXBURST = 8;

  logic CLK;
  logic RST;

  cost_port_arbiter_if #(.NREQ(NREQ)) bus ();

  cost_port_arbiter #(.NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Requester stimulus plans
  int       left   [NREQ];
  bit       nolast [NREQ];
  bit       rq     [NREQ];
  bit       lst    [NREQ];
  bit [2:0] wa     [NREQ];
  bit [2:0] ja     [NREQ];
  bit [6:0] cost;
  bit       sat;
  int       g_prev;

  // Reference model: owner<0 means no burst is locked
  int              m_owner, m_ptr, m_beats;
  bit              m_err;
  logic [NREQ-1:0] m_rvalid;
  logic [6:0]      m_rdata;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = NREQ - 1;
    m_beats  = 0;
    m_err    = 1'b0;
    m_rvalid = '0;
    m_rdata  = '0;
    g_prev   = -1;
  endtask

  function automatic int model_pick();
    int c;
    if (m_owner >= 0) return rq[m_owner] ? m_owner : -1;
    for (int k = 1; k <= NREQ; k++) begin
      c = (m_ptr + k) % NREQ;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      bus.REQ[i]          = rq[i];
      bus.REQ_LAST[i]     = lst[i];
      bus.REQ_W[3*i +: 3] = wa[i];
      bus.REQ_J[3*i +: 3] = ja[i];
    end
    bus.Cost = cost;
  endtask

  task automatic update_plans();
    bit hold;
    for (int i = 0; i < NREQ; i++) begin
      if (g_prev == i) left[i]--;
      if (left[i] == 0 && (sat || $urandom_range(0, 3) == 0)) begin
        left[i]   = sat ? 1 : $urandom_range(1, 10);
        nolast[i] = !sat && ((left[i] > MAXBURST) || ($urandom_range(0, 9) == 0));
      end
      hold = rq[i] && (g_prev != i);
      if (!hold) begin
        rq[i] = (left[i] > 0) && (sat || $urandom_range(0, 5) != 0);
        wa[i] = 3'($urandom);
        ja[i] = 3'($urandom);
      end
      lst[i] = !nolast[i] && (left[i] == 1);
    end
    cost = 7'($urandom);
  endtask

  task automatic check_regs();
    check_value("RVALID", 32'(bus.RVALID), 32'(m_rvalid));
    check_value("RDATA",  32'(bus.RDATA),  32'(m_rdata));
    check_value("BUSY",   32'(bus.BUSY),   32'(m_owner >= 0));
    check_value("ERR",    32'(bus.ERR),    32'(m_err));
  endtask

  // Compare combinational outputs, then advance the model by one clock.
  task automatic check_comb_and_step();
    int g;
    g = model_pick();
    check_value("GNT", 32'(bus.GNT), (g >= 0) ? (32'd1 << g) : 32'd0);
    check_value("W",   32'(bus.W),   (g >= 0) ? 32'(wa[g]) : 32'd0);
    check_value("J",   32'(bus.J),   (g >= 0) ? 32'(ja[g]) : 32'd0);
    if (g >= 0) begin
      m_beats = (m_owner < 0) ? 1 : m_beats + 1;
      if (lst[g] || m_beats == MAXBURST) begin
        if (!lst[g]) m_err = 1'b1;
        m_owner = -1;
        m_ptr   = g;
        m_beats = 0;
      end else begin
        m_owner = g;
      end
      m_rvalid = NREQ'(1) << g;
      m_rdata  = cost;
    end else begin
      m_rvalid = '0;
    end
    g_prev = g;
  endtask

  task automatic check_reset_outputs();
    check_value("RST_GNT",    32'(bus.GNT),    32'd0);
    check_value("RST_W",      32'(bus.W),      32'd0);
    check_value("RST_J",      32'(bus.J),      32'd0);
    check_value("RST_RVALID", 32'(bus.RVALID), 32'd0);
    check_value("RST_RDATA",  32'(bus.RDATA),  32'd0);
    check_value("RST_BUSY",   32'(bus.BUSY),   32'd0);
    check_value("RST_ERR",    32'(bus.ERR),    32'd0);
  endtask

  task automatic clear_plans();
    for (int i = 0; i < NREQ; i++) begin
      left[i] = 0; nolast[i] = 1'b0; rq[i] = 1'b0; lst[i] = 1'b0;
      wa[i] = '0; ja[i] = '0;
    end
    cost = '0;
  endtask

  initial begin
    sat = 1'b0;
    clear_plans();
    drive_bus();
    model_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    #1 check_reset_outputs();
    @(negedge CLK);
    RST = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      sat = (cyc >= 2000) && (cyc < 2200);
      check_regs();
      if (cyc == 1500) begin
        // Asynchronous reset in the middle of traffic; requests stay asserted.
        #2 RST = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        repeat (2) begin
          @(negedge CLK);
          #1 check_reset_outputs();
        end
        @(negedge CLK);
        RST = 1'b1;
        clear_plans();
        left[0] = 3; rq[0] = 1'b1; wa[0] = 3'd5; ja[0] = 3'd1;
        left[2] = 3; rq[2] = 1'b1; wa[2] = 3'd6; ja[2] = 3'd2;
        cost = 7'h2a;
        drive_bus();
        #1 check_value("POSTRST_GNT0", 32'(bus.GNT), 32'd1);
        check_comb_and_step();
      end else begin
        update_plans();
        drive_bus();
        #1 check_comb_and_step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
